// File: rtl/sd_cmd_responder.sv
// Card-side SD CMD line responder: deframes 48-bit host commands (CRC7 checked)
// and answers with an R1-format frame after NCR SD clock rises.
module sd_cmd_responder #(
    parameter int          NCR          = 2,
    parameter logic [63:0] NO_RESP_MASK = 64'h0000_0000_0000_0001
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sd_clock,
    input  logic        sd_cmd_in,
    output logic        sd_cmd_out,
    output logic        sd_cmd_oe,
    output logic        cmd_valid,
    output logic [5:0]  cmd_index,
    output logic [31:0] cmd_arg,
    output logic        crc_err,
    output logic        frame_err,
    input  logic [31:0] resp_status,
    output logic        busy
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_RX    = 3'd1;
    localparam logic [2:0] ST_CHECK = 3'd2;
    localparam logic [2:0] ST_WAIT  = 3'd3;
    localparam logic [2:0] ST_TX    = 3'd4;

    logic        clk_meta_reg, clk_sync_reg, clk_prev_reg;
    logic        cmd_meta_reg, cmd_sync_reg;
    logic        sd_rise, sd_fall;
    logic [2:0]  state_reg;
    logic [47:0] rx_shift_reg;
    logic [5:0]  bit_cnt_reg;
    logic [6:0]  crc_reg;
    logic [39:0] tx_shift_reg;
    logic [6:0]  ncr_cnt_reg;
    logic        ncr_done_reg;

    logic        tx_bit;
    logic [39:0] tx_shift_next;
    logic [6:0]  crc_tx_next;
    logic [5:0]  rx_index;
    logic        rx_no_resp;

    // One serial CRC7 step, polynomial x^7 + x^3 + 1
    function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
        logic fb;
        fb = b ^ c[6];
        return {c[5:3], c[2] ^ fb, c[1:0], fb};
    endfunction

    assign sd_rise    = clk_sync_reg & ~clk_prev_reg;
    assign sd_fall    = ~clk_sync_reg & clk_prev_reg;
    assign rx_index   = rx_shift_reg[45:40];
    assign rx_no_resp = NO_RESP_MASK[rx_index];

    // Response bit selection: 40 payload bits (CRC accumulated as they go), 7 CRC bits, end bit
    always_comb begin
        tx_bit        = 1'b1;
        tx_shift_next = tx_shift_reg;
        crc_tx_next   = {crc_reg[5:0], 1'b0};
        if (bit_cnt_reg < 6'd40) begin
            tx_bit        = tx_shift_reg[39];
            tx_shift_next = {tx_shift_reg[38:0], 1'b0};
            crc_tx_next   = crc7_step(crc_reg, tx_shift_reg[39]);
        end else if (bit_cnt_reg < 6'd47) begin
            tx_bit = crc_reg[6];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            clk_meta_reg <= 1'b0;
            clk_sync_reg <= 1'b0;
            clk_prev_reg <= 1'b0;
            cmd_meta_reg <= 1'b1;
            cmd_sync_reg <= 1'b1;
            state_reg    <= ST_IDLE;
            rx_shift_reg <= '0;
            bit_cnt_reg  <= '0;
            crc_reg      <= '0;
            tx_shift_reg <= '0;
            ncr_cnt_reg  <= '0;
            ncr_done_reg <= 1'b0;
            sd_cmd_out   <= 1'b1;
            sd_cmd_oe    <= 1'b0;
            cmd_valid    <= 1'b0;
            cmd_index    <= '0;
            cmd_arg      <= '0;
            crc_err      <= 1'b0;
            frame_err    <= 1'b0;
            busy         <= 1'b0;
        end else begin
            clk_meta_reg <= sd_clock;
            clk_sync_reg <= clk_meta_reg;
            clk_prev_reg <= clk_sync_reg;
            cmd_meta_reg <= sd_cmd_in;
            cmd_sync_reg <= cmd_meta_reg;
            cmd_valid    <= 1'b0;
            crc_err      <= 1'b0;
            frame_err    <= 1'b0;

            case (state_reg)
                ST_IDLE: begin
                    if (sd_rise && !cmd_sync_reg) begin
                        rx_shift_reg <= '0;
                        bit_cnt_reg  <= 6'd1;
                        crc_reg      <= '0;
                        busy         <= 1'b1;
                        state_reg    <= ST_RX;
                    end
                end
                ST_RX: begin
                    if (sd_rise) begin
                        rx_shift_reg <= {rx_shift_reg[46:0], cmd_sync_reg};
                        if (bit_cnt_reg <= 6'd39)
                            crc_reg <= crc7_step(crc_reg, cmd_sync_reg);
                        if (bit_cnt_reg == 6'd47)
                            state_reg <= ST_CHECK;
                        else
                            bit_cnt_reg <= bit_cnt_reg + 6'd1;
                    end
                end
                ST_CHECK: begin
                    if (rx_shift_reg[47] || !rx_shift_reg[46] || !rx_shift_reg[0]) begin
                        frame_err <= 1'b1;
                        busy      <= 1'b0;
                        state_reg <= ST_IDLE;
                    end else if (rx_shift_reg[7:1] != crc_reg) begin
                        crc_err   <= 1'b1;
                        busy      <= 1'b0;
                        state_reg <= ST_IDLE;
                    end else begin
                        cmd_index    <= rx_index;
                        cmd_arg      <= rx_shift_reg[39:8];
                        cmd_valid    <= 1'b1;
                        tx_shift_reg <= {2'b00, rx_index, resp_status};
                        crc_reg      <= '0;
                        bit_cnt_reg  <= '0;
                        ncr_cnt_reg  <= '0;
                        ncr_done_reg <= 1'b0;
                        if (rx_no_resp) begin
                            busy      <= 1'b0;
                            state_reg <= ST_IDLE;
                        end else begin
                            state_reg <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (sd_rise && !ncr_done_reg) begin
                        if (ncr_cnt_reg == 7'(NCR - 1))
                            ncr_done_reg <= 1'b1;
                        else
                            ncr_cnt_reg <= ncr_cnt_reg + 7'd1;
                    end
                    // Start bit goes out on the first fall after the NCR-th rise
                    if (sd_fall && ncr_done_reg) begin
                        sd_cmd_oe    <= 1'b1;
                        sd_cmd_out   <= tx_bit;
                        tx_shift_reg <= tx_shift_next;
                        crc_reg      <= crc_tx_next;
                        bit_cnt_reg  <= bit_cnt_reg + 6'd1;
                        state_reg    <= ST_TX;
                    end
                end
                ST_TX: begin
                    if (sd_fall) begin
                        if (bit_cnt_reg == 6'd48) begin
                            sd_cmd_oe  <= 1'b0;
                            sd_cmd_out <= 1'b1;
                            busy       <= 1'b0;
                            state_reg  <= ST_IDLE;
                        end else begin
                            sd_cmd_out   <= tx_bit;
                            tx_shift_reg <= tx_shift_next;
                            crc_reg      <= crc_tx_next;
                            bit_cnt_reg  <= bit_cnt_reg + 6'd1;
                        end
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_cmd_responder.sv
// Directed bench for sd_cmd_responder: a host model drives SD clock/CMD and reads back responses.
module tb_sd_cmd_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        sd_clk;
    logic        host_cmd;
    logic        en_b;
    logic        sd_clock_b;
    logic [31:0] status;

    logic        out_a, oe_a, valid_a, crc_a, frm_a, busy_a;
    logic [5:0]  idx_a;
    logic [31:0] arg_a;
    logic        out_b, oe_b, valid_b, crc_b, frm_b, busy_b;
    logic [5:0]  idx_b;
    logic [31:0] arg_b;

    int total = 0;
    int bad   = 0;
    int half  = 4;

    int nv_a = 0, ncrc_a = 0, nfrm_a = 0, noe_a = 0, nv_b = 0;
    logic oe_a_d = 1'b0;

    always #5 clk = ~clk;
    assign sd_clock_b = sd_clk & en_b;

    sd_cmd_responder #(.NCR(2)) dut_a (
        .clk(clk), .reset(reset), .sd_clock(sd_clk), .sd_cmd_in(host_cmd),
        .sd_cmd_out(out_a), .sd_cmd_oe(oe_a), .cmd_valid(valid_a), .cmd_index(idx_a),
        .cmd_arg(arg_a), .crc_err(crc_a), .frame_err(frm_a), .resp_status(status), .busy(busy_a)
    );

    sd_cmd_responder #(.NCR(5)) dut_b (
        .clk(clk), .reset(reset), .sd_clock(sd_clock_b), .sd_cmd_in(host_cmd),
        .sd_cmd_out(out_b), .sd_cmd_oe(oe_b), .cmd_valid(valid_b), .cmd_index(idx_b),
        .cmd_arg(arg_b), .crc_err(crc_b), .frame_err(frm_b), .resp_status(status), .busy(busy_b)
    );

    // Pulse and oe-rise counters, sampled away from the active edge
    always @(negedge clk) begin
        if (valid_a) nv_a++;
        if (crc_a) ncrc_a++;
        if (frm_a) nfrm_a++;
        if (oe_a && !oe_a_d) noe_a++;
        oe_a_d = oe_a;
        if (valid_b) nv_b++;
    end

    // Reference CRC7 by polynomial long division of {data, 7'b0} by 0x89
    function automatic logic [6:0] crc7_ref(input logic [39:0] d);
        logic [46:0] r;
        r = {d, 7'b0};
        for (int i = 46; i >= 7; i--)
            if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
        return r[6:0];
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sd_cycle(input logic b);
        sd_clk   = 1'b0;
        host_cmd = b;
        repeat (half) @(negedge clk);
        sd_clk = 1'b1;
        repeat (half) @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) sd_cycle(1'b1);
    endtask

    task automatic send_frame(input logic [47:0] f);
        for (int i = 47; i >= 0; i--) sd_cycle(f[i]);
        host_cmd = 1'b1;
        repeat (4) @(negedge clk);
        $display("host cmd frame %012h sent", f);
    endtask

    task automatic rx_response(input logic sel, input int ncr, input logic [5:0] idx,
                               input logic [31:0] st);
        logic [47:0] exp_f;
        logic [47:0] got;
        logic        oe_all;
        exp_f = {2'b00, idx, st, crc7_ref({2'b00, idx, st}), 1'b1};
        for (int k = 0; k < ncr; k++) begin
            sd_cycle(1'b1);
            check("ncr_wait_oe", sel ? oe_b : oe_a, 1'b0);
        end
        oe_all = 1'b1;
        for (int j = 47; j >= 0; j--) begin
            sd_cycle(1'b1);
            got[j] = sel ? out_b : out_a;
            oe_all = oe_all & (sel ? oe_b : oe_a);
        end
        check("resp_oe_held", oe_all, 1'b1);
        check("resp_frame", got, exp_f);
        sd_cycle(1'b1);
        check("resp_release_oe", sel ? oe_b : oe_a, 1'b0);
        check("resp_release_out", sel ? out_b : out_a, 1'b1);
        check("resp_busy_clear", sel ? busy_b : busy_a, 1'b0);
        $display("card response %012h received", got);
    endtask

    initial begin
        int v0, c0, f0, o0;
        logic [47:0] f17, f13;
        reset    = 1'b1;
        sd_clk   = 1'b1;
        host_cmd = 1'b1;
        en_b     = 1'b0;
        status   = 32'h0000_0120;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_out", out_a, 1'b1);
        check("rst_oe", oe_a, 1'b0);
        check("rst_valid", valid_a, 1'b0);
        check("rst_crc_err", crc_a, 1'b0);
        check("rst_frame_err", frm_a, 1'b0);
        check("rst_busy", busy_a, 1'b0);
        check("rst_index", idx_a, 6'd0);
        check("rst_arg", arg_a, 32'd0);
        check("rst_oe_b", oe_b, 1'b0);
        idle(4);

        // CMD0: accepted but never answered
        v0 = nv_a; o0 = noe_a;
        send_frame(48'h40_0000_0000_95);
        check("cmd0_valid", nv_a - v0, 1);
        check("cmd0_index", idx_a, 6'd0);
        check("cmd0_busy", busy_a, 1'b0);
        idle(60);
        check("cmd0_no_oe", noe_a - o0, 0);

        // CMD8 with response
        v0 = nv_a;
        send_frame(48'h48_0000_01AA_87);
        check("cmd8_valid", nv_a - v0, 1);
        check("cmd8_index", idx_a, 6'd8);
        check("cmd8_arg", arg_a, 32'h0000_01AA);
        check("cmd8_busy", busy_a, 1'b1);
        rx_response(1'b0, 2, 6'd8, 32'h0000_0120);
        idle(4);

        // CRC error: argument LSB flipped
        v0 = nv_a; c0 = ncrc_a; f0 = nfrm_a; o0 = noe_a;
        send_frame(48'h48_0000_01AB_87);
        idle(10);
        check("crc_pulse", ncrc_a - c0, 1);
        check("crc_no_valid", nv_a - v0, 0);
        check("crc_no_frame", nfrm_a - f0, 0);
        check("crc_index_kept", idx_a, 6'd8);
        check("crc_arg_kept", arg_a, 32'h0000_01AA);
        check("crc_no_resp", noe_a - o0, 0);

        // Transmission bit cleared
        v0 = nv_a; c0 = ncrc_a; f0 = nfrm_a; o0 = noe_a;
        send_frame(48'h08_0000_01AA_87);
        idle(10);
        check("txbit_frame", nfrm_a - f0, 1);
        check("txbit_no_crc", ncrc_a - c0, 0);
        check("txbit_no_valid", nv_a - v0, 0);
        check("txbit_no_resp", noe_a - o0, 0);

        // End bit forced to 0
        v0 = nv_a; c0 = ncrc_a; f0 = nfrm_a; o0 = noe_a;
        send_frame(48'h48_0000_01AA_86);
        idle(10);
        check("endbit_frame", nfrm_a - f0, 1);
        check("endbit_no_crc", ncrc_a - c0, 0);
        check("endbit_no_valid", nv_a - v0, 0);
        check("endbit_no_resp", noe_a - o0, 0);
        check("endbit_arg_kept", arg_a, 32'h0000_01AA);

        // Reset 20 falls into the response
        status = 32'hDEAD_BEEF;
        send_frame(48'h48_0000_01AA_87);
        idle(2 + 21);
        check("midtx_oe_before", oe_a, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        check("midtx_rst_oe", oe_a, 1'b0);
        check("midtx_rst_busy", busy_a, 1'b0);
        check("midtx_rst_out", out_a, 1'b1);
        reset = 1'b0;
        idle(6);
        status = 32'h0000_0120;
        v0 = nv_a;
        send_frame(48'h48_0000_01AA_87);
        check("after_rst_valid", nv_a - v0, 1);
        rx_response(1'b0, 2, 6'd8, 32'h0000_0120);

        // NCR=5 instance at 4:1 clock ratio, back-to-back commands
        half = 2;
        en_b = 1'b1;
        idle(4);
        status = 32'h0000_0900;
        f17 = {8'h51, 32'h0000_1000, crc7_ref(40'h51_0000_1000), 1'b1};
        v0 = nv_b;
        send_frame(f17);
        check("b_cmd17_valid", nv_b - v0, 1);
        check("b_cmd17_index", idx_b, 6'd17);
        check("b_cmd17_arg", arg_b, 32'h0000_1000);
        rx_response(1'b1, 5, 6'd17, 32'h0000_0900);
        idle(7);
        status = 32'h0000_0B00;
        f13 = {8'h4D, 32'hABCD_0000, crc7_ref(40'h4D_ABCD_0000), 1'b1};
        v0 = nv_b;
        send_frame(f13);
        check("b_cmd13_valid", nv_b - v0, 1);
        check("b_cmd13_index", idx_b, 6'd13);
        check("b_cmd13_arg", arg_b, 32'hABCD_0000);
        rx_response(1'b1, 5, 6'd13, 32'h0000_0B00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired before end of test");
        $fatal(1, "watchdog");
    end

endmodule
